// File: rtl/mode_sequencer.sv
// mode_sequencer: debounces the start button, latches the one-hot processor mode, sequences the
// processor reset and supervises a run until the halt PC (or a timeout) is seen.
// Optional feature: define MODE_SEQ_TIMEOUT_EN to end a run after MAX_CYCLES cycles with error.
module mode_sequencer #(
  parameter int unsigned          DEBOUNCE_CYCLES = 16,
  parameter int unsigned          RST_CYCLES      = 4,
  parameter int unsigned          PC_WIDTH        = 16,
  parameter logic [PC_WIDTH-1:0]  HALT_PC         = '1
`ifdef MODE_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned          MAX_CYCLES      = 1000
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_btn,
  input  logic [2:0]          sw_mode,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                proc_rst,
  output logic                mode_xor,
  output logic                mode_rshift,
  output logic                mode_lshift,
  output logic                mode_ecae,
  output logic                mode_dcae,
  output logic                mode_mul,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         cycle_count
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
  localparam logic [DbW-1:0]  DbMax   = DbW'(DEBOUNCE_CYCLES);
  localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StResetProc, StRun, StDone} state_e;

  // Reset release chain: assertion is immediate, release is aligned to clk.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // Shift ones into the release chain once rst is deasserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Button path.
  logic [1:0]     btn_sync_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           db_level_q, db_level_d;
  logic           db_level_prev_q;
  logic           start_evt_q;

  // Debounce: count while the synced input disagrees with the accepted level.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (btn_sync_q[1] == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbMax) begin
      db_level_d = ~db_level_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  // Synchronizer, debounce state and registered rising-edge start pulse.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      btn_sync_q      <= '0;
      db_cnt_q        <= '0;
      db_level_q      <= 1'b0;
      db_level_prev_q <= 1'b0;
      start_evt_q     <= 1'b0;
    end else begin
      btn_sync_q      <= {btn_sync_q[0], start_btn};
      db_cnt_q        <= db_cnt_d;
      db_level_q      <= db_level_d;
      db_level_prev_q <= db_level_q;
      start_evt_q     <= db_level_q & ~db_level_prev_q;
    end
  end

  // Sequencer state and datapath.
  state_e          state_q, state_d;
  logic [5:0]      mode_q, mode_d;
  logic [15:0]     count_q, count_d;
  logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
  logic            error_q, error_d;
  logic            mode_valid;
  logic            halt;
  logic            timeout;

  assign mode_valid = (sw_mode <= 3'd5);
  assign halt       = (pc == HALT_PC);

`ifdef MODE_SEQ_TIMEOUT_EN
  localparam logic [15:0] MaxCnt = 16'(MAX_CYCLES);
  // The cycle that would bring the count to MAX_CYCLES is the last one allowed.
  assign timeout = (count_q == MaxCnt - 16'd1);
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    rst_cnt_d = rst_cnt_q;
    error_d   = error_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_evt_q) begin
          if (mode_valid) begin
            state_d = StLoad;
            error_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // An invalid code arriving this late yields all-zero modes, never multi-hot.
        case (sw_mode)
          3'd0:    mode_d = 6'b000001;
          3'd1:    mode_d = 6'b000010;
          3'd2:    mode_d = 6'b000100;
          3'd3:    mode_d = 6'b001000;
          3'd4:    mode_d = 6'b010000;
          3'd5:    mode_d = 6'b100000;
          default: mode_d = 6'b000000;
        endcase
        count_d   = '0;
        rst_cnt_d = '0;
        state_d   = StResetProc;
      end
      StResetProc: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StRun: begin
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
        // Halt takes priority over a coincident timeout.
        if (halt) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StDone;
          error_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      mode_q    <= '0;
      count_q   <= '0;
      rst_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      count_q   <= count_d;
      rst_cnt_q <= rst_cnt_d;
      error_q   <= error_d;
    end
  end

  // State-decoded outputs.
  always_comb begin
    proc_rst = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle:      ;
      StLoad:      busy = 1'b1;
      StResetProc: busy = 1'b1;
      StRun: begin
        busy     = 1'b1;
        proc_rst = 1'b0;
      end
      StDone:      done = 1'b1;
      default:     ;
    endcase
  end

  assign mode_xor    = mode_q[0];
  assign mode_rshift = mode_q[1];
  assign mode_lshift = mode_q[2];
  assign mode_ecae   = mode_q[3];
  assign mode_dcae   = mode_q[4];
  assign mode_mul    = mode_q[5];
  assign error       = error_q;
  assign cycle_count = count_q;

endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Front-end controller directly upstream of the vector processor. It debounces a start button and latches a 3-bit mode selection into the processor's one-hot mode inputs (mode_xor … mode_mul). It sequences the processor's reset, supervises the run until a halt PC or a timeout, and reports busy/done/error plus a run-length cycle count.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a button level change (≥2).
- RST_CYCLES, 4: cycles proc_rst is held high before a run (≥1).
- PC_WIDTH, 16: width of pc input.
- HALT_PC, 16'hFFFF: PC value that ends a run.
- MAX_CYCLES, 1000: run timeout in cycles (only with MODE_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_btn  in  1  raw, asynchronous start button, active-high.
- sw_mode  in  3  mode code: 0 xor, 1 rshift, 2 lshift, 3 ecae, 4 dcae, 5 mul; 6–7 invalid.
- pc  in  PC_WIDTH  processor program counter.
- proc_rst  out  1  active-high reset to processor.
- mode_xor, mode_rshift, mode_lshift, mode_ecae, mode_dcae, mode_mul  out  1 each  one-hot mode to processor.
- busy  out  1  high in LOAD, RESET_PROC and RUN.
- done  out  1  high in DONE.
- error  out  1  sticky fault flag.
- cycle_count  out  16  RUN cycles of the current/last run.

## Operation
- Reset values (rst low, asynchronous): state IDLE, proc_rst=1, all mode_* =0, busy=0, done=0, error=0, cycle_count=0, synchronizer/debounce state 0.
- Button path: 2-FF synchronizer → debounce counter. The counter counts while the sync output differs from the debounced level, clears when they match, and toggles the level when DEBOUNCE_CYCLES is reached. A start event is a rising edge of the debounced level (single-cycle pulse).
- FSM:
  - IDLE: proc_rst=1, modes 0. On start event: if sw_mode ≤5 → LOAD, clear error; else set error, stay IDLE.
  - LOAD (1 cycle): latch sw_mode into one-hot mode register; cycle_count←0; → RESET_PROC.
  - RESET_PROC: proc_rst=1, modes driven; after RST_CYCLES cycles → RUN.
  - RUN: proc_rst=0. cycle_count increments each cycle, saturating at 16'hFFFF. If pc==HALT_PC → DONE. Timeout per Configuration → DONE with error=1.
  - DONE: proc_rst=1, modes held, cycle_count held, done=1. On start event with valid sw_mode → LOAD (error cleared); with invalid sw_mode → error=1, stay DONE.
- Start events outside IDLE/DONE are ignored.
- sw_mode changes outside LOAD have no effect on outputs.
- Mode outputs are registered, exactly one-hot or all-zero, never multi-hot.

## Timing
- From first start_btn high sample: 2 sync cycles + DEBOUNCE_CYCLES to the debounced level, +1 cycle to the edge pulse. The FSM enters LOAD on the following edge.
- LOAD→RUN: 1 + RST_CYCLES cycles; proc_rst falls on the edge entering RUN.
- Halt: pc==HALT_PC sampled in RUN cycle N → DONE at cycle N+1. cycle_count counts cycle N.
- Halt and timeout in the same cycle: halt wins, error stays 0.
- pc==HALT_PC during RESET_PROC is ignored.
- rst asserted mid-run: all outputs take their reset values immediately, not synchronized to clk. Deassertion is synchronized: rst is released into the state logic through a 2-FF release chain.

## Configuration
- MODE_SEQ_TIMEOUT_EN defined: RUN ends when cycle_count reaches MAX_CYCLES without halt → DONE, error=1.
- MODE_SEQ_TIMEOUT_EN undefined: no timeout logic. RUN waits indefinitely for HALT_PC, and error is set only by an invalid sw_mode.

## Test plan
- Reset: rst=0 at arbitrary point → proc_rst=1, modes=0, busy=done=error=0, cycle_count=0 same cycle.
- Debounce: start_btn glitch high for DEBOUNCE_CYCLES−1 cycles → no LOAD. Held high → LOAD exactly 2+DEBOUNCE_CYCLES+2 cycles after first high sample.
- Valid run: sw_mode=5, start, pc=HALT_PC on RUN cycle 10 → mode_mul=1 only, proc_rst low for 10 cycles, done=1, cycle_count=10, error=0.
- Invalid mode: sw_mode=7, start → stays IDLE, error=1, modes 0. Then sw_mode=0 and start → LOAD, error=0, mode_xor=1.
- Timeout (macro on, MAX_CYCLES=20): pc never halts → DONE after cycle_count=20, error=1. Halt at count 20 → error=0.
- Re-run from DONE with sw_mode=3 → mode_ecae=1, cycle_count restarts at 0, busy=1.
